ni_arbiter: RTL and testbench

- N-master to 1-slave arbiter for the Native Interface (NI) write/read protocol, with round-robin grant.
- Placed between several NI masters (CPU bridge, DMA, debug port) and one NI register slave.
- Serialises one transaction at a time, forwards it to the slave and routes the response back to the granted master.
- Adds a per-transaction response timeout with error reporting; the plain single-channel NI interface has no timeout.

---
 rtl/ni_arbiter.sv | 154 +++++++++++++++
 tb/tb_ni_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ni_arbiter.sv
// N-master to 1-slave Native Interface arbiter: round-robin grant, one transaction
// in flight at a time, per-transaction response timeout with error reporting.
module ni_arbiter #(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_MASTERS-1:0]              m_wen,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_waddr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_wdata,
  output logic [NUM_MASTERS-1:0]              m_wack,
  input  logic [NUM_MASTERS-1:0]              m_ren,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_raddr,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_rdata,
  output logic [NUM_MASTERS-1:0]              m_rvalid,
  output logic                                s_wen,
  output logic [ADDR_WIDTH-1:0]               s_waddr,
  output logic [DATA_WIDTH-1:0]               s_wdata,
  input  logic                                s_wack,
  output logic                                s_ren,
  output logic [ADDR_WIDTH-1:0]               s_raddr,
  input  logic [DATA_WIDTH-1:0]               s_rdata,
  input  logic                                s_rvalid,
  output logic                                busy,
  output logic [$clog2(NUM_MASTERS)-1:0]      grant_id,
  output logic                                timeout_err,
  output logic [15:0]                         timeout_cnt
);

  localparam int unsigned GW   = $clog2(NUM_MASTERS);
  localparam int unsigned TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TLIM = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [DATA_WIDTH-1:0] ERR_WORD = DATA_WIDTH'(ERR_DATA);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t          state, state_n;
  logic [GW-1:0]   rr;
  logic [GW-1:0]   rr_next;
  logic [GW-1:0]   sel;
  logic [GW-1:0]   lane;
  logic            found;
  logic [NUM_MASTERS-1:0] req;
  logic [TW-1:0]   tcnt;
  logic            tmo_hit;
  logic            tmo_fire;
  int unsigned     idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    req     = m_wen | m_ren;
    found   = 1'b0;
    sel     = '0;
    lane    = '0;
    idx     = 0;
    // Round-robin search: first requester at or after rr, wrapping around.
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      idx = 32'(rr) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      lane = GW'(idx);
      if (!found && req[lane]) begin
        found = 1'b1;
        sel   = lane;
      end
    end

    tmo_hit  = (TIMEOUT_CYCLES != 0) && (tcnt == TW'(TLIM));
    // A response on the timeout edge wins and completes normally.
    tmo_fire = tmo_hit && (((state == WRITE) && !s_wack) || ((state == READ) && !s_rvalid));
    rr_next  = (grant_id == GW'(NUM_MASTERS - 1)) ? '0 : grant_id + 1'b1;

    state_n = state;
    case (state)
      IDLE:    if (found) state_n = m_wen[sel] ? WRITE : READ;
      WRITE:   if (s_wack || tmo_hit) state_n = DONE;
      READ:    if (s_rvalid || tmo_hit) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr          <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
      tcnt        <= '0;
      s_wen       <= 1'b0;
      s_waddr     <= '0;
      s_wdata     <= '0;
      s_ren       <= 1'b0;
      s_raddr     <= '0;
      m_wack      <= '0;
      m_rvalid    <= '0;
      m_rdata     <= '0;
      timeout_err <= 1'b0;
      timeout_cnt <= '0;
    end else begin
      timeout_err <= 1'b0;
      if (tmo_fire) begin
        timeout_err <= 1'b1;
        if (timeout_cnt != '1) timeout_cnt <= timeout_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (found) begin
            grant_id <= sel;
            busy     <= 1'b1;
            tcnt     <= '0;
            if (m_wen[sel]) begin
              s_wen   <= 1'b1;
              s_waddr <= m_waddr[sel*ADDR_WIDTH +: ADDR_WIDTH];
              s_wdata <= m_wdata[sel*DATA_WIDTH +: DATA_WIDTH];
            end else begin
              s_ren   <= 1'b1;
              s_raddr <= m_raddr[sel*ADDR_WIDTH +: ADDR_WIDTH];
            end
          end
        end
        WRITE: begin
          tcnt <= tcnt + 1'b1;
          if (s_wack || tmo_hit) begin
            s_wen            <= 1'b0;
            m_wack[grant_id] <= 1'b1;
          end
        end
        READ: begin
          tcnt <= tcnt + 1'b1;
          if (s_rvalid || tmo_hit) begin
            s_ren              <= 1'b0;
            m_rvalid[grant_id] <= 1'b1;
            m_rdata[grant_id*DATA_WIDTH +: DATA_WIDTH] <= s_rvalid ? s_rdata : ERR_WORD;
          end
        end
        DONE: begin
          m_wack   <= '0;
          m_rvalid <= '0;
          busy     <= 1'b0;
          rr       <= rr_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ni_arbiter.sv
// Randomized bench for ni_arbiter against a transaction-level round-robin model
// with a responsive, slow, or silent slave.
module tb_ni_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int TO = 16;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    m_wen, m_ren, m_wack, m_rvalid;
  logic [N*AW-1:0] m_waddr, m_raddr;
  logic [N*DW-1:0] m_wdata, m_rdata;
  logic            s_wen, s_wack, s_ren, s_rvalid;
  logic [AW-1:0]   s_waddr, s_raddr;
  logic [DW-1:0]   s_wdata, s_rdata;
  logic            busy, timeout_err;
  logic [1:0]      grant_id;
  logic [15:0]     timeout_cnt;

  ni_arbiter #(
    .NUM_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TO), .ERR_DATA(ERRD)
  ) dut (
    .clk(clk), .rst(rst),
    .m_wen(m_wen), .m_waddr(m_waddr), .m_wdata(m_wdata), .m_wack(m_wack),
    .m_ren(m_ren), .m_raddr(m_raddr), .m_rdata(m_rdata), .m_rvalid(m_rvalid),
    .s_wen(s_wen), .s_waddr(s_waddr), .s_wdata(s_wdata), .s_wack(s_wack),
    .s_ren(s_ren), .s_raddr(s_raddr), .s_rdata(s_rdata), .s_rvalid(s_rvalid),
    .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err), .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference state: pending requests per master, their payloads, rr pointer,
  // each master's last read data and the timeout tally.
  bit            pw[N], pr[N];
  logic [AW-1:0] wa[N], ra[N];
  logic [DW-1:0] wd[N], exp_rd[N];
  int            rr, tcount;
  int            gd, g;
  int            rr_exp[6] = '{0, 1, 3, 0, 1, 3};
  int            wr_exp[4] = '{0, 1, 3, 0};

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int i = (rr + k) % N;
      if (pw[i] || pr[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N*DW-1:0] pack_rd();
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = exp_rd[i];
    return v;
  endfunction

  task automatic drive_masters();
    for (int i = 0; i < N; i++) begin
      m_wen[i] = pw[i];
      m_ren[i] = pr[i];
      m_waddr[i*AW +: AW] = wa[i];
      m_wdata[i*DW +: DW] = wd[i];
      m_raddr[i*AW +: AW] = ra[i];
    end
  endtask

  task automatic do_reset();
    s_wack = 1'b0;
    s_rvalid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_slave", {s_wen, s_waddr, s_wdata, s_ren, s_raddr}, '0);
    check("rst_master", {m_wack, m_rvalid, m_rdata}, '0);
    check("rst_status", {busy, grant_id, timeout_err, timeout_cnt}, '0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rr = 0;
    tcount = 0;
    for (int i = 0; i < N; i++) exp_rd[i] = '0;
  endtask

  // lat = edge (counted from the grant) at which the slave answers; 0 = never.
  task automatic run_txn(input int lat, input logic [DW-1:0] rd, output int gdut);
    int gm;
    bit w, fin;
    logic [N-1:0] onehot;
    gm = pick();
    gdut = -1;
    if (gm < 0) return;
    w = pw[gm];
    onehot = '0;
    onehot[gm] = 1'b1;
    drive_masters();
    @(posedge clk); #1;
    s_wack = 1'b0;
    s_rvalid = 1'b0;
    gdut = int'(grant_id);
    check("grant_id", grant_id, gm);
    check("grant_req", {busy, s_wen, s_ren}, {1'b1, w, !w});
    if (w) check("s_waddr_wdata", {s_waddr, s_wdata}, {wa[gm], wd[gm]});
    else   check("s_raddr", s_raddr, ra[gm]);
    for (int c = 1; c <= TO; c++) begin
      if (w) begin
        s_wack = (c == lat);
        s_rvalid = 1'($urandom);
      end else begin
        s_rvalid = (c == lat);
        s_wack = 1'($urandom);
        s_rdata = (c == lat) ? rd : DW'($urandom);
      end
      fin = (c == lat) || (lat == 0 && c == TO);
      @(posedge clk); #1;
      s_wack = 1'b0;
      s_rvalid = 1'b0;
      if (!fin) begin
        check("wait", {busy, s_wen, s_ren, m_wack, m_rvalid, timeout_err},
              {1'b1, w, !w, {(2*N){1'b0}}, 1'b0});
      end else begin
        if (!w) exp_rd[gm] = (lat == 0) ? ERRD : rd;
        if (lat == 0 && tcount < 16'hFFFF) tcount++;
        check("resp_pulse", {m_wack, m_rvalid}, w ? {onehot, {N{1'b0}}} : {{N{1'b0}}, onehot});
        check("resp_drop", {busy, s_wen, s_ren, timeout_err}, {1'b1, 2'b00, lat == 0});
        check("m_rdata", m_rdata, pack_rd());
        check("timeout_cnt", timeout_cnt, tcount);
        if (w) pw[gm] = 1'b0;
        else   pr[gm] = 1'b0;
        drive_masters();
        break;
      end
    end
    // Late responses during DONE must be ignored.
    s_wack = 1'b1;
    s_rvalid = 1'b1;
    s_rdata = DW'($urandom);
    @(posedge clk); #1;
    s_wack = 1'b0;
    s_rvalid = 1'b0;
    check("done", {busy, s_wen, s_ren, m_wack, m_rvalid, timeout_err}, '0);
    check("m_rdata_hold", m_rdata, pack_rd());
    rr = (gm + 1) % N;
  endtask

  initial begin
    int r, lat;
    rst = 1'b0;
    s_wack = 1'b0;
    s_rvalid = 1'b0;
    s_rdata = '0;
    for (int i = 0; i < N; i++) begin
      pw[i] = 1'b0; pr[i] = 1'b0; wa[i] = '0; ra[i] = '0; wd[i] = '0; exp_rd[i] = '0;
    end
    drive_masters();
    #2 do_reset();

    pw[2] = 1'b1; wa[2] = 16'h0010; wd[2] = 32'hA5A5_0001;
    run_txn(3, '0, gd);
    check("wr_grant", gd, 2);

    pr[1] = 1'b1; ra[1] = 16'h0020;
    run_txn(2, 32'h1234_5678, gd);
    check("rd_lane1", m_rdata[63:32], 32'h1234_5678);

    do_reset();
    pr[0] = 1'b1; pr[1] = 1'b1; pr[3] = 1'b1;
    ra[0] = AW'($urandom); ra[1] = AW'($urandom); ra[3] = AW'($urandom);
    for (int k = 0; k < 6; k++) begin
      g = pick();
      run_txn(1 + k % 3, $urandom, gd);
      check("rr_order", gd, rr_exp[k]);
      pr[g] = 1'b1;
      ra[g] = AW'($urandom);
    end

    pw[0] = 1'b1; wa[0] = AW'($urandom); wd[0] = $urandom;
    for (int k = 0; k < 4; k++) begin
      run_txn(2, $urandom, gd);
      check("wr_rd_order", gd, wr_exp[k]);
    end

    pr[3] = 1'b1; ra[3] = 16'h0300;
    run_txn(0, '0, gd);
    check("tmo_lane3", m_rdata[127:96], 32'hDEAD_BEEF);
    check("tmo_cnt", timeout_cnt, 16'd1);

    for (int t = 0; t < 150; t++) begin
      if (t == 75) begin
        for (int i = 0; i < N; i++) begin pw[i] = 1'b0; pr[i] = 1'b0; end
        pw[2] = 1'b1; wa[2] = AW'($urandom); wd[2] = $urandom;
        drive_masters();
        @(posedge clk); #1;
        check("mid_write", {busy, s_wen, grant_id}, {2'b11, 2'd2});
        do_reset();
        pr[1] = 1'b1; ra[1] = AW'($urandom);
        pr[3] = 1'b1; ra[3] = AW'($urandom);
        run_txn(2, $urandom, gd);
        check("post_rst_grant", gd, 1);
      end
      for (int i = 0; i < N; i++) begin
        if (!pw[i] && $urandom_range(0, 3) == 0) begin
          pw[i] = 1'b1; wa[i] = AW'($urandom); wd[i] = $urandom;
        end
        if (!pr[i] && $urandom_range(0, 3) == 0) begin
          pr[i] = 1'b1; ra[i] = AW'($urandom);
        end
      end
      if (pick() < 0) begin
        r = $urandom_range(0, N - 1);
        pr[r] = 1'b1;
        ra[r] = AW'($urandom);
      end
      s_wack = 1'($urandom);
      s_rvalid = 1'($urandom);
      r = $urandom_range(0, 9);
      lat = (r == 0) ? 0 : (r == 1) ? TO : $urandom_range(1, 5);
      run_txn(lat, $urandom, gd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
